// File: rtl/data_path.sv
// data_path: single-bus Mini-SRC datapath with register file, ALU, CON logic, I/O ports and 512x32 RAM
module data_path (
  input  logic        clock,
  input  logic        clear,
  input  logic        PCout,
  input  logic        Zhighout,
  input  logic        Zlowout,
  input  logic        MDRout,
  input  logic        HIout,
  input  logic        LOout,
  input  logic        Yout,
  input  logic        InPortout,
  input  logic        Cout,
  input  logic        Rout,
  input  logic        BAout,
  input  logic        MARin,
  input  logic        PCin,
  input  logic        MDRin,
  input  logic        IRin,
  input  logic        Yin,
  input  logic        HIin,
  input  logic        LOin,
  input  logic        ZHighIn,
  input  logic        ZLowIn,
  input  logic        Rin,
  input  logic        Gra,
  input  logic        Grb,
  input  logic        Grc,
  input  logic        IncPC,
  input  logic        Read,
  input  logic        Write,
  input  logic [4:0]  opcode,
  input  logic        CONin,
  input  logic        OutPortin,
  input  logic [8:0]  Address,
  input  logic [31:0] Mdatain,
  input  logic [31:0] InPortData,
  output logic [31:0] OutPortData,
  output logic        R0out,
  output logic        R1out,
  output logic        R2out,
  output logic        R3out,
  output logic        R4out,
  output logic        R5out,
  output logic        R6out,
  output logic        R7out,
  output logic        R8out,
  output logic        R9out,
  output logic        R10out,
  output logic        R11out,
  output logic        R12out,
  output logic        R13out,
  output logic        R14out,
  output logic        R15out
);
  logic [31:0] r [16];
  logic [31:0] ram [512];
  logic [31:0] pc, ir, mar, mdr, y, hi, lo, inport, bus, c_sext, r_val, quot, rem;
  logic [63:0] z, alu, prod, dbl, rot_r, rot_l;
  logic [3:0]  idx;
  logic [15:0] r_drive;
  logic        con, cond;
  logic [4:0]  sh;
  logic        unused_bits;

  assign idx = ({4{Gra}} & ir[26:23]) | ({4{Grb}} & ir[22:19]) | ({4{Grc}} & ir[18:15]);
  assign r_drive = (16'd1 << idx) & {16{Rout | BAout}};
  assign {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
          R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out} = r_drive;
  assign r_val = (BAout && idx == 4'd0) ? 32'd0 : r[idx];
  assign c_sext = {{13{ir[18]}}, ir[18:0]};

  assign bus = (Rout | BAout) ? r_val :
               HIout      ? hi :
               LOout      ? lo :
               Zhighout   ? z[63:32] :
               Zlowout    ? z[31:0] :
               PCout      ? pc :
               MDRout     ? mdr :
               InPortout  ? inport :
               Cout       ? c_sext :
               Yout       ? y : 32'd0;

  assign sh = bus[4:0];
  assign dbl = {y, y};
  assign rot_r = dbl >> sh;
  assign rot_l = dbl << sh;
  assign prod = $signed({{32{y[31]}}, y}) * $signed({{32{bus[31]}}, bus});
  assign quot = $signed(y) / $signed(bus);
  assign rem = $signed(y) % $signed(bus);
  assign unused_bits = ^{ir[31:27], mar[31:9], rot_r[63:32], rot_l[31:0]};

  assign cond = (ir[20:19] == 2'b00) ? (bus == 32'd0) :
                (ir[20:19] == 2'b01) ? (bus != 32'd0) :
                (ir[20:19] == 2'b10) ? !bus[31] : bus[31];

  // ALU: IncPC overrides the opcode; unknown opcodes pass the bus through
  always_comb begin
    alu = {32'd0, bus};
    if (IncPC) alu = {32'd0, bus + 32'd1};
    else
      case (opcode)
        5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b01100: alu = {32'd0, y + bus};
        5'b00100: alu = {32'd0, y - bus};
        5'b00101, 5'b01101: alu = {32'd0, y & bus};
        5'b00110, 5'b01110: alu = {32'd0, y | bus};
        5'b00111: alu = {32'd0, rot_r[31:0]};
        5'b01000: alu = {32'd0, rot_l[63:32]};
        5'b01001: alu = {32'd0, y >> sh};
        5'b01010: alu = {32'd0, $signed(y) >>> sh};
        5'b01011: alu = {32'd0, y << sh};
        5'b10000: alu = prod;
        5'b01111: alu = (bus == 32'd0) ? 64'd0 : {rem, quot};
        5'b10001: alu = {32'd0, -bus};
        5'b10010: alu = {32'd0, ~bus};
        default: alu = {32'd0, bus};
      endcase
  end

  // architectural registers load from the bus (or ALU / RAM) on their strobes
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < 16; i++) r[i] <= '0;
      pc <= '0;
      ir <= '0;
      mar <= '0;
      mdr <= '0;
      y <= '0;
      z <= '0;
      hi <= '0;
      lo <= '0;
      con <= 1'b0;
      inport <= '0;
      OutPortData <= '0;
    end else begin
      if (Rin) r[idx] <= bus;
      if (PCin) pc <= bus;
      if (IRin) ir <= bus;
      if (MARin) mar <= bus;
      if (MDRin) mdr <= Read ? ram[mar[8:0]] : bus;
      if (Yin) y <= bus;
      if (HIin) hi <= bus;
      if (LOin) lo <= bus;
      if (ZHighIn) z[63:32] <= alu[63:32];
      if (ZLowIn) z[31:0] <= alu[31:0];
      if (CONin) con <= cond;
      if (OutPortin) OutPortData <= bus;
      inport <= InPortData;
    end
  end

  // RAM: preload port while in reset, MDR write-back otherwise
  always_ff @(posedge clock) begin
    if (!clear) ram[Address] <= Mdatain;
    else if (Write) ram[mar[8:0]] <= mdr;
  end
endmodule

// File: tb/tb_data_path.sv
// tb_data_path: directed scoreboard bench for data_path
module tb_data_path;
  logic clock = 1'b0;
  logic clear = 1'b1;
  logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Yout, InPortout, Cout, Rout, BAout;
  logic MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn, Rin, Gra, Grb, Grc;
  logic IncPC, Read, Write, CONin, OutPortin, peek;
  logic [4:0]  opcode;
  logic [8:0]  Address = '0;
  logic [31:0] Mdatain = '0, InPortData = '0, OutPortData;
  logic R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out;
  logic R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out;

  typedef struct {
    string       name;
    logic [31:0] d;
    logic [15:0] r;
    bit          chk_r;
    bit          is_con;
  } exp_t;
  exp_t q[$];
  int errors = 0;
  int checks = 0;

  data_path dut (
    .clock(clock), .clear(clear),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .Yout(Yout), .InPortout(InPortout), .Cout(Cout),
    .Rout(Rout), .BAout(BAout), .MARin(MARin), .PCin(PCin), .MDRin(MDRin),
    .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin), .ZHighIn(ZHighIn),
    .ZLowIn(ZLowIn), .Rin(Rin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC),
    .Read(Read), .Write(Write), .opcode(opcode), .CONin(CONin), .OutPortin(OutPortin),
    .Address(Address), .Mdatain(Mdatain), .InPortData(InPortData),
    .OutPortData(OutPortData),
    .R0out(R0out), .R1out(R1out), .R2out(R2out), .R3out(R3out),
    .R4out(R4out), .R5out(R5out), .R6out(R6out), .R7out(R7out),
    .R8out(R8out), .R9out(R9out), .R10out(R10out), .R11out(R11out),
    .R12out(R12out), .R13out(R13out), .R14out(R14out), .R15out(R15out)
  );

  always #5 clock = ~clock;

  task automatic zero();
    {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Yout, InPortout, Cout, Rout, BAout,
     MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn, Rin, Gra, Grb, Grc,
     IncPC, Read, Write, CONin, OutPortin, peek} = '0;
    opcode = '0;
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
    zero();
  endtask

  task automatic observe(input string n, input logic [31:0] d, input logic [15:0] r, input bit chk_r);
    q.push_back('{n, d, r, chk_r, 1'b0});
    OutPortin = 1'b1;
    cyc();
  endtask

  task automatic expect_con(input string n, input logic v);
    q.push_back('{n, {31'd0, v}, 16'd0, 1'b0, 1'b1});
    CONin = 1'b1;
    cyc();
  endtask

  task automatic set_ir(input logic [31:0] v);
    InPortData = v;
    cyc();
    InPortout = 1'b1; IRin = 1'b1;
    cyc();
  endtask

  task automatic set_reg(input logic [3:0] rn, input logic [31:0] v);
    set_ir({5'd0, rn, 23'd0});
    InPortData = v;
    cyc();
    InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1;
    cyc();
  endtask

  task automatic load_y(input logic [31:0] v);
    InPortData = v;
    cyc();
    InPortout = 1'b1; Yin = 1'b1;
    cyc();
  endtask

  task automatic alu(input string n, input logic [4:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic inc, input logic [31:0] lo);
    load_y(a);
    InPortData = b;
    cyc();
    InPortout = 1'b1; opcode = op; IncPC = inc; ZHighIn = 1'b1; ZLowIn = 1'b1;
    cyc();
    Zlowout = 1'b1;
    observe(n, lo, 16'd0, 1'b0);
  endtask

  task automatic fetch();
    PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1;
    cyc();
    Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
    cyc();
    MDRout = 1'b1; IRin = 1'b1;
    cyc();
  endtask

  // monitor: compares whenever the DUT loads OutPortData or CON, or a hold is probed
  initial begin
    forever begin
      logic [15:0] rv;
      logic        con_ev;
      exp_t        e;
      @(posedge clock);
      if (clear && (OutPortin || CONin || peek)) begin
        rv = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
              R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
        con_ev = CONin && !OutPortin;
        #2;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got out=%h with no expectation queued", OutPortData);
        end else begin
          e = q.pop_front();
          if (e.is_con != con_ev) begin
            errors++;
            $display("FAIL %s: event kind got con=%0b required con=%0b", e.name, con_ev, e.is_con);
          end else if (e.is_con) begin
            if (dut.con !== e.d[0]) begin
              errors++;
              $display("FAIL %s: con got %b required %b", e.name, dut.con, e.d[0]);
            end
          end else if (OutPortData !== e.d || (e.chk_r && rv !== e.r)) begin
            errors++;
            $display("FAIL %s: out got %h required %h, rdrive got %h required %h",
                     e.name, OutPortData, e.d, rv, e.chk_r ? e.r : rv);
          end
        end
      end
    end
  end

  initial begin
    zero();
    InPortData = 32'h0000_DEAD;
    cyc();
    InPortout = 1'b1; PCin = 1'b1; Yin = 1'b1; IRin = 1'b1;
    observe("pre_out", 32'h0000_DEAD, 16'd0, 1'b0);
    InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1;
    cyc();
    clear = 1'b0;
    for (int i = 0; i < 2; i++) begin
      Address = 9'(i);
      Mdatain = (i == 0) ? 32'hB180_0000 : 32'hB980_0000;
      InPortData = 32'h1234;
      PCin = 1'b1; InPortout = 1'b1; Yin = 1'b1; Rin = 1'b1; Gra = 1'b1;
      OutPortin = 1'b1; MDRin = 1'b1; IRin = 1'b1; CONin = 1'b1;
      @(posedge clock);
      #1;
    end
    zero();
    InPortData = '0;
    clear = 1'b1;
    q.push_back('{"rst_out", 32'd0, 16'd0, 1'b0, 1'b0});
    peek = 1'b1;
    cyc();
    PCout = 1'b1;
    observe("rst_pc", 32'd0, 16'd0, 1'b0);
    Yout = 1'b1;
    observe("rst_y", 32'd0, 16'd0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      set_ir({5'd0, 4'(i), 23'd0});
      Gra = 1'b1; Rout = 1'b1;
      observe($sformatf("rst_r%0d", i), 32'd0, 16'(1 << i), 1'b1);
    end

    fetch();
    Gra = 1'b1; Rout = 1'b1;
    observe("fetch_ir_ra", 32'd0, 16'h0008, 1'b1);
    PCout = 1'b1;
    observe("fetch_pc", 32'd1, 16'd0, 1'b0);

    InPortData = 32'h30;
    cyc();
    Gra = 1'b1; Rin = 1'b1; InPortout = 1'b1;
    cyc();
    fetch();
    Gra = 1'b1; Rout = 1'b1;
    observe("out_r3", 32'h30, 16'h0008, 1'b1);
    PCout = 1'b1;
    observe("fetch2_pc", 32'd2, 16'd0, 1'b0);

    set_reg(4'd4, 32'd5);
    set_reg(4'd5, 32'd7);
    set_ir({5'd0, 4'd4, 23'd0});
    Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
    cyc();
    set_ir({5'd0, 4'd5, 23'd0});
    Gra = 1'b1; Rout = 1'b1; opcode = 5'b00011; ZLowIn = 1'b1;
    cyc();
    Zlowout = 1'b1;
    observe("add", 32'd12, 16'd0, 1'b0);

    alu("mul_lo", 5'b10000, 32'hFFFF_FFFD, 32'd6, 1'b0, 32'hFFFF_FFEE);
    Zhighout = 1'b1;
    observe("mul_hi", 32'hFFFF_FFFF, 16'd0, 1'b0);
    alu("div_lo", 5'b01111, 32'd17, 32'd5, 1'b0, 32'd3);
    Zhighout = 1'b1; HIin = 1'b1;
    cyc();
    Zlowout = 1'b1; LOin = 1'b1;
    cyc();
    HIout = 1'b1;
    observe("div_hi_reg", 32'd2, 16'd0, 1'b0);
    LOout = 1'b1;
    observe("div_lo_reg", 32'd3, 16'd0, 1'b0);
    alu("div0_lo", 5'b01111, 32'd17, 32'd0, 1'b0, 32'd0);
    Zhighout = 1'b1;
    observe("div0_hi", 32'd0, 16'd0, 1'b0);
    alu("sdiv_lo", 5'b01111, 32'hFFFF_FFEF, 32'd5, 1'b0, 32'hFFFF_FFFD);
    Zhighout = 1'b1;
    observe("sdiv_hi", 32'hFFFF_FFFE, 16'd0, 1'b0);
    alu("sub", 5'b00100, 32'd5, 32'd7, 1'b0, 32'hFFFF_FFFE);
    alu("and", 5'b00101, 32'h0000_F0F0, 32'h0000_FF00, 1'b0, 32'h0000_F000);
    alu("or", 5'b01110, 32'h0000_F0F0, 32'h0000_0F0F, 1'b0, 32'h0000_FFFF);
    alu("shra", 5'b01010, 32'h8000_0000, 32'd4, 1'b0, 32'hF800_0000);
    alu("shr", 5'b01001, 32'h8000_0000, 32'd4, 1'b0, 32'h0800_0000);
    alu("shl", 5'b01011, 32'h0000_0003, 32'd36, 1'b0, 32'h0000_0030);
    alu("ror", 5'b00111, 32'h0000_0001, 32'd1, 1'b0, 32'h8000_0000);
    alu("rol", 5'b01000, 32'h8000_0000, 32'd1, 1'b0, 32'h0000_0001);
    alu("neg", 5'b10001, 32'd99, 32'd5, 1'b0, 32'hFFFF_FFFB);
    alu("not", 5'b10010, 32'd99, 32'd0, 1'b0, 32'hFFFF_FFFF);
    alu("incpc", 5'b00100, 32'd100, 32'd9, 1'b1, 32'd10);
    alu("dflt", 5'b11111, 32'd1, 32'h77, 1'b0, 32'h77);

    set_ir(32'd0);
    Gra = 1'b1; Rout = 1'b1;
    expect_con("con_eq0", 1'b1);
    set_ir(32'h0018_0000);
    InPortData = 32'h8000_0000;
    cyc();
    InPortout = 1'b1;
    expect_con("con_neg", 1'b1);
    InPortData = 32'd0;
    cyc();
    InPortout = 1'b1;
    expect_con("con_neg_f", 1'b0);
    set_ir(32'h0008_0000);
    InPortData = 32'd5;
    cyc();
    InPortout = 1'b1;
    expect_con("con_ne0", 1'b1);

    set_reg(4'd0, 32'h55);
    set_ir(32'd0);
    Gra = 1'b1; BAout = 1'b1;
    observe("ba_r0", 32'd0, 16'h0001, 1'b1);
    Gra = 1'b1; Rout = 1'b1;
    observe("rout_r0", 32'h55, 16'h0001, 1'b1);
    set_ir(32'h0004_0001);
    Cout = 1'b1;
    observe("c_sext", 32'hFFFC_0001, 16'd0, 1'b0);

    InPortData = 32'd5;
    cyc();
    InPortout = 1'b1; MARin = 1'b1;
    cyc();
    InPortData = 32'hABCD;
    cyc();
    InPortout = 1'b1; MDRin = 1'b1;
    cyc();
    Write = 1'b1;
    cyc();
    InPortData = 32'h1111;
    cyc();
    InPortout = 1'b1; MDRin = 1'b1;
    cyc();
    Read = 1'b1; MDRin = 1'b1; Write = 1'b1;
    cyc();
    MDRout = 1'b1;
    observe("rw_old", 32'hABCD, 16'd0, 1'b0);
    Read = 1'b1; MDRin = 1'b1;
    cyc();
    MDRout = 1'b1;
    observe("rw_new", 32'h1111, 16'd0, 1'b0);
    InPortData = 32'h2222;
    cyc();
    InPortout = 1'b1; MDRin = 1'b1;
    cyc();
    InPortData = 32'd6;
    cyc();
    InPortout = 1'b1; MARin = 1'b1; Read = 1'b1; MDRin = 1'b1;
    cyc();
    MDRout = 1'b1;
    observe("read_old_mar", 32'h1111, 16'd0, 1'b0);

    cyc();
    cyc();
    while (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: got no output, required %h", e.name, e.d);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
